// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// ---------------------------------------------------------------------------
// Elastic pipeline stage register that sits between two pipeline stages. It
// carries a control bundle and a data payload. The control bundle reads as
// zero whenever no beat is presented, so a bubble is always a zero control
// word. With SKID_EN=1 the stage holds two entries (main + skid), which keeps
// in_ready a function of registered state only. With SKID_EN=0 it holds a
// single entry, and in_ready passes out_ready through combinationally.
//
// Handshake: a beat moves across a port on a rising edge where valid and
// ready are both 1. A producer holding valid=1 keeps its beat stable until
// that edge. ready may depend on the other side's valid/ready only as
// described for in_ready below.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   flush         drop every held entry (redirect); data registers keep value
//   in_valid      upstream beat present
//   in_ready      stage can take a beat this cycle
//   in_ctrl       upstream control bundle      [CTRL_W]
//   in_data       upstream payload             [DATA_W]
//   out_valid     beat presented downstream
//   out_ready     downstream accepts
//   out_ctrl      presented control, zero when out_valid=0
//   out_data      presented payload, holds last main value when idle
//   cnt_clr       clear the stall counter
//   stall_cnt     saturating count of cycles with out_valid=1, out_ready=0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int CTRL_W  = 28,
    parameter int DATA_W  = 32,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // state_q is the observable FSM state for checkers bound to this block
    state_t            state_q;
    state_t            state_d;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;

    logic acc;
    logic rel;
    logic ld_main_in;
    logic ld_main_skid;
    logic ld_skid;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign out_data  = main_data_q;

    // With a skid entry the stage can always absorb one more beat unless both
    // entries are occupied, so in_ready needs no look at out_ready.
    always_comb begin
        in_ready = 1'b0;
        if (SKID_EN != 0) begin
            in_ready = (state_q != ST_SKID) & ~rst;
        end else begin
            in_ready = (~out_valid | out_ready) & ~rst;
        end
    end

    assign acc = in_valid & in_ready;
    assign rel = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d    = ST_FULL;
                    ld_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (acc && rel) begin
                    ld_main_in = 1'b1;
                end else if (acc) begin
                    // Only reachable with a skid entry; in single-entry mode
                    // in_ready is low whenever a held beat is not leaving.
                    if (SKID_EN != 0) begin
                        state_d = ST_SKID;
                        ld_skid = 1'b1;
                    end
                end else if (rel) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (rel) begin
                    state_d      = ST_FULL;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (flush) begin
            // Data is left alone so out_data keeps showing the old payload.
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q <= state_d;
            if (ld_main_in) begin
                main_ctrl_q <= in_ctrl;
                main_data_q <= in_data;
            end else if (ld_main_skid) begin
                main_ctrl_q <= skid_ctrl_q;
                main_data_q <= skid_data_q;
            end
            if (ld_skid) begin
                skid_ctrl_q <= in_ctrl;
                skid_data_q <= in_data;
            end
        end
    end

    // Counts presented-but-blocked cycles; flush does not disturb it.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one two-entry instance (16-bit counter) and one
// single-entry instance (4-bit counter) share every input, and each is checked
// every cycle against a small FIFO model of the stage.
module tb_pipe_stage_reg;

    localparam int CW = 28;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic          ir_a, ov_a, ir_b, ov_b;
    logic [CW-1:0] oc_a, oc_b;
    logic [DW-1:0] od_a, od_b;
    logic [15:0]   sc_a;
    logic [3:0]    sc_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // model: per instance, an ordered buffer of held beats (front = presented)
    logic [CW-1:0] m_ctrl[2][2];
    logic [DW-1:0] m_data[2][2];
    int            m_n[2];
    logic [DW-1:0] m_last[2];
    int            m_stall[2];

    // scoreboard of beats accepted by the single-entry instance
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_a), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_ctrl(oc_a), .out_data(od_a),
        .cnt_clr(cnt_clr), .stall_cnt(sc_a)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_b), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov_b), .out_ready(out_ready), .out_ctrl(oc_b), .out_data(od_b),
        .cnt_clr(cnt_clr), .stall_cnt(sc_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Ready rule: two-entry stage takes a beat while it holds fewer than two;
    // single-entry stage takes one when empty or when its beat is leaving.
    function automatic logic m_ir(input int d);
        if (rst) return 1'b0;
        if (d == 0) return (m_n[0] < 2);
        return (m_n[1] == 0) || out_ready;
    endfunction

    task automatic check_dut(input int d);
        logic          ir, ov;
        logic [CW-1:0] oc;
        logic [DW-1:0] od;
        logic [15:0]   sc;
        string         p;
        p = (d == 0) ? "skid" : "noskid";
        if (d == 0) begin
            ir = ir_a; ov = ov_a; oc = oc_a; od = od_a; sc = sc_a;
        end else begin
            ir = ir_b; ov = ov_b; oc = oc_b; od = od_b; sc = {12'b0, sc_b};
        end
        chk({p, ".in_ready"},  64'(ir), 64'(m_ir(d)));
        chk({p, ".out_valid"}, 64'(ov), 64'(m_n[d] > 0));
        chk({p, ".out_ctrl"},  64'(oc), (m_n[d] > 0) ? 64'(m_ctrl[d][0]) : 64'(0));
        chk({p, ".out_data"},  64'(od), 64'(m_last[d]));
        chk({p, ".stall_cnt"}, 64'(sc), 64'(m_stall[d]));
    endtask

    task automatic model_edge(input int d);
        bit acc, rel;
        int sat;
        sat = (d == 0) ? 65535 : 15;
        if (rst) begin
            m_n[d] = 0; m_last[d] = '0; m_stall[d] = 0;
            return;
        end
        acc = in_valid && m_ir(d);
        rel = (m_n[d] > 0) && out_ready;
        if (cnt_clr) m_stall[d] = 0;
        else if ((m_n[d] > 0) && !out_ready && (m_stall[d] < sat)) m_stall[d]++;
        if (flush) begin
            m_n[d] = 0;
            return;
        end
        if (rel) begin
            m_ctrl[d][0] = m_ctrl[d][1];
            m_data[d][0] = m_data[d][1];
            m_n[d]--;
        end
        if (acc) begin
            m_ctrl[d][m_n[d]] = in_ctrl;
            m_data[d][m_n[d]] = in_data;
            m_n[d]++;
        end
        if (m_n[d] > 0) m_last[d] = m_data[d][0];
    endtask

    // One clock cycle: drive inputs just after the falling edge, check outputs
    // 1 ns later, advance the model for the rising edge, return at next fall.
    task automatic step(input logic r, input logic f, input logic iv, input logic orr,
                        input logic cc, input logic [CW-1:0] c, input logic [DW-1:0] dd);
        rst = r; flush = f; in_valid = iv; out_ready = orr; cnt_clr = cc;
        in_ctrl = c; in_data = dd;
        #1;
        if (chk_en) begin
            check_dut(0);
            check_dut(1);
        end
        if (rst) begin
            exp_q.delete();
        end else begin
            if (chk_en && (m_n[1] > 0) && out_ready && (exp_q.size() > 0))
                chk("noskid.scoreboard", 64'(od_b), 64'(exp_q.pop_front()));
            if (flush) exp_q.delete();
            else if (in_valid && m_ir(1)) exp_q.push_back(in_data);
        end
        model_edge(0);
        model_edge(1);
        if (r) chk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_n[d] = 0; m_last[d] = '0; m_stall[d] = 0;
            for (int k = 0; k < 2; k++) begin
                m_ctrl[d][k] = '0; m_data[d][k] = '0;
            end
        end
        @(negedge clk);

        // reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        chk("reset.out_valid", 64'(ov_a), 64'(0));
        chk("reset.out_ctrl",  64'(oc_a), 64'(0));
        chk("reset.out_data",  64'(od_a), 64'(0));
        chk("reset.stall_cnt", 64'(sc_a), 64'(0));
        chk("reset.in_ready",  64'(ir_a), 64'(0));

        // streaming at full rate
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, CW'(i + 1), DW'(32'hA0 + i));
        idle(3);
        chk("stream.stall_cnt", 64'(sc_a), 64'(0));

        // skid capture and release
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, CW'(1), DW'(32'h11));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(2), DW'(32'h22));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("skid.in_ready_low", 64'(ir_a), 64'(0));
        chk("skid.main_0x11", 64'(od_a), 64'(32'h11));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("skid.next_0x22", 64'(od_a), 64'(32'h22));
        chk("skid.in_ready_back", 64'(ir_a), 64'(1));
        idle(2);

        // flush while both entries are held, with a beat on offer
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(4), DW'(32'h44));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(5), DW'(32'h55));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, CW'(3), DW'(32'h33));
        chk("flush.out_valid", 64'(ov_a), 64'(0));
        chk("flush.out_ctrl",  64'(oc_a), 64'(0));
        chk("flush.out_data",  64'(od_a), 64'(32'h44));
        chk("flush.in_ready",  64'(ir_a), 64'(1));
        idle(2);

        // stall counter and saturation
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, CW'(6), DW'(32'h66));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("stall.count20", 64'(sc_a), 64'(20));
        chk("stall.saturate", 64'(sc_b), 64'(15));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        chk("stall.clr_a", 64'(sc_a), 64'(0));
        chk("stall.clr_b", 64'(sc_b), 64'(0));
        idle(3);

        // out_ready toggling under continuous in_valid
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 1'b1, (i % 2) == 1, 1'b0, CW'(16 + i), DW'(32'hB0 + i));
        idle(3);

        // random traffic with occasional flush, clear and reset
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0, CW'($urandom), $urandom);
        idle(3);

        // reset while both entries are held
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(7), DW'(32'h77));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(8), DW'(32'h88));
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CW'(9), DW'(32'h99));
        chk("midrst.out_valid", 64'(ov_a), 64'(0));
        chk("midrst.out_ctrl",  64'(oc_a), 64'(0));
        chk("midrst.out_data",  64'(od_a), 64'(0));
        chk("midrst.stall_cnt", 64'(sc_a), 64'(0));
        chk("midrst.in_ready",  64'(ir_a), 64'(0));
        chk("midrst.b_out_data", 64'(od_b), 64'(0));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("midrst.in_ready_after", 64'(ir_a), 64'(1));
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
